line_zoom_controller: RTL and testbench
=======================================

# line_zoom_controller

Sequencer for the `line_buffer` block that implements integer nearest-neighbour zoom. Once the buffer reports a full input line, the controller streams that line to the zoom output. Each pixel is emitted `factor` times horizontally, and the whole line is replayed `factor` times vertically. The buffer is then released for the next input line. It sits between `line_buffer` (read side plus the `repeat_line` and `clear_line_full_flag` controls) and the downstream zoom/pixel consumer.

## Interface
- `LINE_DEPTH`, 4: pixels per input line; must match the connected `line_buffer`.
- `PIXEL_WIDTH`, 8: pixel width in bits.
- `MAX_FACTOR`, 4: largest zoom factor accepted; `zoom_factor` is 3 bits wide, so `MAX_FACTOR` ≤ 7.

Ports:
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `enable`  in  1  allows the controller to accept new lines.
- `zoom_factor`  in  3  requested factor; latched per line.
- `lb_line_full`  in  1  `line_full` from the buffer.
- `lb_valid`  in  1  `valid_out_zoom` from the buffer.
- `lb_data`  in  PIXEL_WIDTH  `data_out_zoom` from the buffer.
- `lb_ready`  out  1  `ready_in_zoom` to the buffer; advances `rd_ptr`.
- `lb_repeat_line`  out  1  `repeat_line` to the buffer; resets `rd_ptr` to 0.
- `lb_clear_full`  out  1  `clear_line_full_flag` to the buffer.
- `pix_out`  out  PIXEL_WIDTH  zoomed pixel.
- `pix_valid`  out  1  `pix_out` is valid.
- `pix_ready`  in  1  consumer accepts a pixel.
- `pix_last_col`  out  1  current pixel is the last of its output row.
- `pix_last_row`  out  1  current output row is the last row generated from this input line.
- `line_done`  out  1  one-cycle pulse when an input line has been fully consumed.
- `busy`  out  1  state is not IDLE.

## Operation
- **Factor latch:** `f` is the effective factor. `zoom_factor` = 0 is treated as 1. Values above `MAX_FACTOR` are clamped to `MAX_FACTOR`.
- **Counters:**
  - `h_cnt` (0..f-1): horizontal repeat of the current pixel.
  - `col` (0..LINE_DEPTH-1): input pixel index.
  - `v_cnt` (0..f-1): output row index.
- **State IDLE:** all control outputs 0. If `enable`=1, go to WAIT_FULL.
- **State WAIT_FULL:**
  - If `lb_line_full`=1: latch `f`, clear all counters, go to EMIT.
  - Otherwise, if `enable`=0, go to IDLE.
- **State EMIT:**
  - Output: `pix_out`=`lb_data`; `pix_valid`=`lb_valid`.
  - A pixel handshake `hs` = `pix_valid` & `pix_ready`.
  - On `hs`, `h_cnt` increments. When `h_cnt`=f-1, `h_cnt` wraps to 0 and `col` increments.
  - `lb_ready` = `hs` & (`h_cnt`==f-1), asserted combinationally.
  - `pix_last_col` = (`col`==LINE_DEPTH-1) & (`h_cnt`==f-1).
  - `pix_last_row` = (`v_cnt`==f-1).
  - On `hs` with `pix_last_col`=1:
    - If `v_cnt`<f-1, go to NEXT_ROW.
    - Otherwise go to RELEASE.
- **State NEXT_ROW:** `lb_repeat_line`=1 for one cycle; `v_cnt`++, `col`=0, `h_cnt`=0; go to EMIT.
- **State RELEASE:**
  - `lb_repeat_line`=1 and `lb_clear_full`=1 in the same cycle, so `rd_ptr` returns to 0 before the next line.
  - `line_done`=1; counters cleared.
  - Go to WAIT_FULL if `enable`=1, otherwise IDLE.
- **End-of-line detection:** the controller counts pixels itself. Because `rd_ptr` wraps and `lb_valid` can remain high after the last read, `lb_valid` is never used to detect the end of a line.
- **`enable`=0 mid-line:** the current line completes through RELEASE; then the controller goes to IDLE.
- **`rst`=1 at any edge:** state returns to IDLE and all counters clear. The line buffer is reset by the same `rst`.

## Timing
- **Reset values:** `lb_ready`, `lb_repeat_line`, `lb_clear_full`, `pix_valid`, `pix_last_col`, `pix_last_row`, `line_done` and `busy` are all 0. `pix_out` follows `lb_data`.
- **Data path:** `lb_data`→`pix_out` and `lb_valid`→`pix_valid` are combinational; zero latency in EMIT.
- **Handshake rules:**
  - `pix_valid` is gated by state: it is 0 outside EMIT.
  - `pix_out` is held stable while `pix_valid`=1 and `pix_ready`=0.
  - `lb_ready` never asserts without `hs` in the same cycle.
- **Line start latency:**
  - `lb_line_full` rises at edge N; WAIT_FULL samples it at edge N+1.
  - The first `pix_valid` appears in the cycle after edge N+1 (EMIT).
- **Throughput:**
  - Each output row is LINE_DEPTH·f pixels at up to one pixel per cycle.
  - One bubble cycle (NEXT_ROW) separates consecutive rows.
  - One bubble cycle (RELEASE) follows the last row.
  - With continuous `pix_ready`, one input line costs f·(LINE_DEPTH·f+1)+1 cycles, counting from EMIT entry through RELEASE.
- **Buffer release:** `lb_line_full` falls at the edge ending RELEASE; the writer may refill from the next cycle.
- **`pix_ready` low:** counters and state hold, with no timeout.

## Test plan
- **f=1 pass-through:** `rst`, then `enable`=1, fill pixels 10,20,30,40, `pix_ready`=1.
  - Output is 10,20,30,40 with `pix_last_col` and `pix_last_row` on 40.
  - One `lb_clear_full`/`line_done` pulse; 4 `lb_ready` pulses.
- **f=2:** same line.
  - Output is 10,10,20,20,30,30,40,40 twice.
  - One `lb_repeat_line` bubble between the rows; `pix_last_row` only on the second row.
  - 8 `lb_ready` pulses in total; cycle count is 19.
- **Backpressure:** f=3, `pix_ready` toggling 1010….
  - `pix_out` is stable while stalled.
  - Exactly 12 handshakes per row and 3 rows; `lb_ready` only on every third handshake.
- **Factor handling:**
  - `zoom_factor`=0 behaves as f=1.
  - `zoom_factor`=7 with `MAX_FACTOR`=4 gives 16 pixels × 4 rows.
  - Changing `zoom_factor` mid-line has no effect until the next line.
- **Back-to-back lines and `enable` drop:** two lines at f=2, with `enable` dropped during the first line.
  - The first line completes.
  - Then the controller is IDLE with `busy`=0 and the second line is not consumed until `enable` returns.
- **Reset mid-row:** assert `rst` during EMIT at `col`=2.
  - On the next edge all outputs are 0 and the state is IDLE.
  - After refill, the line restarts at pixel 0.

Source files
------------

// File: rtl/line_zoom_controller.sv
// -----------------------------------------------------------------------------
// line_zoom_controller
//
// Sequencer that drives the read side of a line_buffer to produce an integer
// nearest-neighbour zoom. When the buffer holds a full input line, every pixel
// is emitted f times horizontally and the whole line is replayed f times
// vertically. After the last row the buffer is released for the next line.
//
// Parameters
//   LINE_DEPTH   pixels per input line (must match the line_buffer)
//   PIXEL_WIDTH  pixel width in bits
//   MAX_FACTOR   largest zoom factor accepted (<= 7, zoom_factor is 3 bits)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   enable          allows the controller to accept new lines
//   zoom_factor     requested factor, latched once per line
//   lb_line_full    line_full from the buffer
//   lb_valid        valid_out_zoom from the buffer
//   lb_data         data_out_zoom from the buffer
//   lb_ready        ready_in_zoom to the buffer (advances rd_ptr)
//   lb_repeat_line  repeat_line to the buffer (rd_ptr back to 0)
//   lb_clear_full   clear_line_full_flag to the buffer
//   pix_out         zoomed pixel
//   pix_valid       pix_out is valid
//   pix_ready       consumer accepts a pixel
//   pix_last_col    current pixel is the last of its output row
//   pix_last_row    current output row is the last for this input line
//   line_done       one-cycle pulse when an input line has been consumed
//   busy            controller is not idle
// -----------------------------------------------------------------------------
module line_zoom_controller #(
    parameter int LINE_DEPTH  = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_FACTOR  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [2:0]             zoom_factor,
    input  logic                   lb_line_full,
    input  logic                   lb_valid,
    input  logic [PIXEL_WIDTH-1:0] lb_data,
    output logic                   lb_ready,
    output logic                   lb_repeat_line,
    output logic                   lb_clear_full,
    output logic [PIXEL_WIDTH-1:0] pix_out,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_last_col,
    output logic                   pix_last_row,
    output logic                   line_done,
    output logic                   busy
);

    localparam int               COL_W    = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_DEPTH - 1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [2:0]       F_MAX    = 3'(MAX_FACTOR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FULL,
        S_EMIT,
        S_NEXT_ROW,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       f_q, f_d;
    logic [2:0]       h_cnt_q, h_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [2:0]       v_cnt_q, v_cnt_d;

    logic [2:0] f_eff;
    logic [2:0] f_last;
    logic       h_last;
    logic       col_last;
    logic       v_last;
    logic       emit_valid;
    logic       hs;

    // Effective factor: 0 behaves as 1, anything above MAX_FACTOR is clamped.
    always_comb begin
        if (zoom_factor == 3'd0) begin
            f_eff = 3'd1;
        end else if (zoom_factor > F_MAX) begin
            f_eff = F_MAX;
        end else begin
            f_eff = zoom_factor;
        end
    end

    assign f_last     = f_q - 3'd1;
    assign h_last     = (h_cnt_q == f_last);
    assign col_last   = (col_q == COL_LAST);
    assign v_last     = (v_cnt_q == f_last);
    assign emit_valid = (state_q == S_EMIT) && lb_valid;
    assign hs         = emit_valid && pix_ready;

    // -------------------------------------------------------------------------
    // State and counter registers
    // -------------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values; reset is synchronous, so it lives inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            f_q     <= 3'd1;
            h_cnt_q <= 3'd0;
            col_q   <= '0;
            v_cnt_q <= 3'd0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            h_cnt_q <= h_cnt_d;
            col_q   <= col_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_FULL;
            end
            S_WAIT_FULL: begin
                if (lb_line_full) begin
                    state_d = S_EMIT;
                end else if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                // End of a row is found by counting, never from lb_valid,
                // because the buffer keeps valid high after its last read.
                if (hs && col_last && h_last) begin
                    state_d = v_last ? S_RELEASE : S_NEXT_ROW;
                end
            end
            S_NEXT_ROW: state_d = S_EMIT;
            S_RELEASE:  state_d = enable ? S_WAIT_FULL : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Counter / factor next values
    // -------------------------------------------------------------------------
    always_comb begin
        f_d     = f_q;
        h_cnt_d = h_cnt_q;
        col_d   = col_q;
        v_cnt_d = v_cnt_q;
        unique case (state_q)
            S_WAIT_FULL: begin
                if (lb_line_full) begin
                    f_d     = f_eff;
                    h_cnt_d = 3'd0;
                    col_d   = '0;
                    v_cnt_d = 3'd0;
                end
            end
            S_EMIT: begin
                if (hs) begin
                    if (h_last) begin
                        h_cnt_d = 3'd0;
                        col_d   = col_last ? '0 : col_q + COL_ONE;
                    end else begin
                        h_cnt_d = h_cnt_q + 3'd1;
                    end
                end
            end
            S_NEXT_ROW: begin
                v_cnt_d = v_cnt_q + 3'd1;
                col_d   = '0;
                h_cnt_d = 3'd0;
            end
            default: begin
                // IDLE and RELEASE: start every line from a clean slate.
                h_cnt_d = 3'd0;
                col_d   = '0;
                v_cnt_d = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pix_out = lb_data;

    always_comb begin
        lb_ready       = 1'b0;
        lb_repeat_line = 1'b0;
        lb_clear_full  = 1'b0;
        pix_valid      = 1'b0;
        pix_last_col   = 1'b0;
        pix_last_row   = 1'b0;
        line_done      = 1'b0;
        busy           = (state_q != S_IDLE);
        unique case (state_q)
            S_EMIT: begin
                pix_valid    = emit_valid;
                // Only the last horizontal copy of a pixel consumes it.
                lb_ready     = hs && h_last;
                pix_last_col = col_last && h_last;
                pix_last_row = v_last;
            end
            S_NEXT_ROW: begin
                lb_repeat_line = 1'b1;
            end
            S_RELEASE: begin
                // Rewind and release together so rd_ptr is 0 for the next line.
                lb_repeat_line = 1'b1;
                lb_clear_full  = 1'b1;
                line_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_zoom_controller.sv
// -----------------------------------------------------------------------------
// tb_line_zoom_controller
//
// Drives line_zoom_controller against a small behavioural line_buffer. The
// stimulus side pushes the expected zoomed pixel stream into a scoreboard; a
// monitor pops and compares on every pixel handshake.
// -----------------------------------------------------------------------------
module tb_line_zoom_controller;

    localparam int LD = 4;
    localparam int PW = 8;
    localparam int MF = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [2:0]    zoom_factor;
    logic          lb_line_full;
    logic          lb_valid;
    logic [PW-1:0] lb_data;
    logic          lb_ready;
    logic          lb_repeat_line;
    logic          lb_clear_full;
    logic [PW-1:0] pix_out;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last_col;
    logic          pix_last_row;
    logic          line_done;
    logic          busy;

    always #5 clk = ~clk;

    line_zoom_controller #(
        .LINE_DEPTH (LD),
        .PIXEL_WIDTH(PW),
        .MAX_FACTOR (MF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .zoom_factor   (zoom_factor),
        .lb_line_full  (lb_line_full),
        .lb_valid      (lb_valid),
        .lb_data       (lb_data),
        .lb_ready      (lb_ready),
        .lb_repeat_line(lb_repeat_line),
        .lb_clear_full (lb_clear_full),
        .pix_out       (pix_out),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_last_col  (pix_last_col),
        .pix_last_row  (pix_last_row),
        .line_done     (line_done),
        .busy          (busy)
    );

    // -------------------------------------------------------------------------
    // Behavioural line_buffer
    // -------------------------------------------------------------------------
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [PW-1:0] wr_data;
    logic [PW-1:0] mem [LD];
    logic [1:0]    rd_ptr;
    logic          full_q;

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rst) begin
            rd_ptr <= 2'd0;
            full_q <= 1'b0;
        end else begin
            if (wr_en && wr_addr == 2'd3) full_q <= 1'b1;
            else if (lb_clear_full)       full_q <= 1'b0;
            if (lb_repeat_line)  rd_ptr <= 2'd0;
            else if (lb_ready)   rd_ptr <= rd_ptr + 2'd1;
        end
    end

    assign lb_line_full = full_q;
    assign lb_valid     = full_q;
    assign lb_data      = mem[rd_ptr];

    // -------------------------------------------------------------------------
    // Scoreboard and counters
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [PW-1:0] px;
        logic          lc;
        logic          lr;
        logic          hl;
    } exp_t;

    exp_t          sb [$];
    logic [PW-1:0] cur_px [LD];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            hs_total = 0;
    int            rdy_total = 0;
    int            rep_total = 0;
    int            clr_total = 0;
    int            done_total = 0;
    logic          bp_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready: always 1, or alternating 1,0,1,0 under backpressure.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = bp_mode ? ~pix_ready : 1'b1;
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    logic          stall_q  = 1'b0;
    logic [PW-1:0] stall_px = '0;

    always @(negedge clk) begin
        exp_t e;
        if (pix_valid && pix_ready) begin
            hs_total++;
            check("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pix_out", pix_out, e.px);
                check("pix_last_col", pix_last_col, e.lc);
                check("pix_last_row", pix_last_row, e.lr);
                check("lb_ready_on_hs", lb_ready, e.hl);
            end
        end else begin
            check("lb_ready_without_hs", lb_ready, 32'd0);
        end
        if (stall_q && pix_valid) check("stall_hold", pix_out, stall_px);
        stall_q  = pix_valid && !pix_ready;
        stall_px = pix_out;
        rdy_total  += int'(lb_ready);
        rep_total  += int'(lb_repeat_line);
        clr_total  += int'(lb_clear_full);
        done_total += int'(line_done);
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic fill(input logic [PW-1:0] p0, p1, p2, p3);
        cur_px[0] = p0; cur_px[1] = p1; cur_px[2] = p2; cur_px[3] = p3;
        for (int i = 0; i < LD; i++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(i);
            wr_data = cur_px[i];
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
    endtask

    task automatic push_line(input int f);
        exp_t e;
        for (int v = 0; v < f; v++)
            for (int c = 0; c < LD; c++)
                for (int h = 0; h < f; h++) begin
                    e.px = cur_px[c];
                    e.lc = (c == LD - 1) && (h == f - 1);
                    e.lr = (v == f - 1);
                    e.hl = (h == f - 1);
                    sb.push_back(e);
                end
    endtask

    // Runs one line to line_done. zf_mid >= 0 changes zoom_factor and drop_en
    // drops enable, both three cycles after the first pixel appears.
    task automatic run_line(input int f, input int zf_mid, input bit drop_en, input bit chk_lat);
        int s_hs, s_rdy, s_rep, s_clr, s_done;
        int t0, t1, n;
        push_line(f);
        s_hs = hs_total; s_rdy = rdy_total; s_rep = rep_total;
        s_clr = clr_total; s_done = done_total;
        t0 = -1; t1 = -1; n = 0;
        while (t1 < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (t0 < 0 && pix_valid) begin
                t0 = n;
                // line_full rose at the edge before the first sample; EMIT
                // starts one edge later.
                if (chk_lat) check("start_latency", n, 32'd2);
            end
            if (t0 >= 0 && n == t0 + 3) begin
                #1;
                if (zf_mid >= 0) zoom_factor = 3'(zf_mid);
                if (drop_en) enable = 1'b0;
            end
            if (line_done) t1 = n;
        end
        check("line_done_seen", {31'd0, t1 >= 0}, 32'd1);
        @(posedge clk);
        #1;
        // Edges from EMIT entry through the edge ending RELEASE, inclusive.
        if (!bp_mode && t1 >= 0) check("line_cycles", t1 - t0 + 2, f * (LD * f + 1) + 1);
        check("hs_count", hs_total - s_hs, LD * f * f);
        check("lb_ready_count", rdy_total - s_rdy, LD * f);
        check("repeat_count", rep_total - s_rep, f);
        check("clear_full_count", clr_total - s_clr, 32'd1);
        check("line_done_count", done_total - s_done, 32'd1);
        check("sb_drained", sb.size(), 32'd0);
        sb.delete();
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        int k, n, s_hs;
        rst = 1'b1; enable = 1'b0; zoom_factor = 3'd1;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = '0;
        for (int i = 0; i < LD; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {lb_ready, lb_repeat_line, lb_clear_full, pix_valid,
               pix_last_col, pix_last_row, line_done, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // f=1 pass-through
        enable = 1'b1; zoom_factor = 3'd1;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait_full_busy_novalid", {busy, pix_valid}, 32'd2);
        fill(8'd10, 8'd20, 8'd30, 8'd40);
        run_line(1, -1, 1'b0, 1'b1);

        // f=2
        zoom_factor = 3'd2;
        fill(8'd10, 8'd20, 8'd30, 8'd40);
        run_line(2, -1, 1'b0, 1'b1);

        // Backpressure at f=3
        zoom_factor = 3'd3; bp_mode = 1'b1;
        fill(8'd51, 8'd52, 8'd53, 8'd54);
        run_line(3, -1, 1'b0, 1'b1);
        bp_mode = 1'b0;
        @(posedge clk); #1;

        // zoom_factor 0 behaves as 1, 7 clamps to MAX_FACTOR
        zoom_factor = 3'd0;
        fill(8'd1, 8'd2, 8'd3, 8'd4);
        run_line(1, -1, 1'b0, 1'b1);
        zoom_factor = 3'd7;
        fill(8'd5, 8'd6, 8'd7, 8'd8);
        run_line(MF, -1, 1'b0, 1'b1);

        // Mid-line factor change only affects the following line
        zoom_factor = 3'd2;
        fill(8'd11, 8'd12, 8'd13, 8'd14);
        run_line(2, 1, 1'b0, 1'b1);
        fill(8'd15, 8'd16, 8'd17, 8'd18);
        run_line(1, -1, 1'b0, 1'b1);

        // enable dropped mid-line: line finishes, then idle until re-enabled
        zoom_factor = 3'd2;
        fill(8'd21, 8'd22, 8'd23, 8'd24);
        run_line(2, -1, 1'b1, 1'b1);
        @(negedge clk);
        check("idle_after_drop", busy, 32'd0);
        s_hs = hs_total;
        fill(8'd31, 8'd32, 8'd33, 8'd34);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        check("idle_holds_line", {busy, lb_line_full}, 32'd1);
        check("no_pixels_while_idle", hs_total - s_hs, 32'd0);
        #1;
        enable = 1'b1;
        run_line(2, -1, 1'b0, 1'b0);

        // Reset in the middle of a row (col=2 is the fifth handshake at f=2)
        zoom_factor = 3'd2;
        fill(8'd41, 8'd42, 8'd43, 8'd44);
        push_line(2);
        k = 0; n = 0;
        while (k < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (pix_valid && pix_ready) k++;
        end
        check("reached_col2", k, 32'd5);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs",
              {lb_ready, lb_repeat_line, lb_clear_full, pix_valid,
               pix_last_col, pix_last_row, line_done, busy}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        fill(8'd41, 8'd42, 8'd43, 8'd44);
        run_line(2, -1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
